// File: rtl/otp_cipher_ctrl_if.sv
// Handshake bundle for otp_cipher_ctrl: two requesters, pad source,
// cipher drive/return, result port and status.
interface otp_cipher_ctrl_if #(
  parameter int BITS  = 64,
  parameter int CNT_W = 16
);
  logic              req0_valid;
  logic [BITS-1:0]   req0_msg;
  logic              req0_ready;
  logic              req1_valid;
  logic [BITS-1:0]   req1_msg;
  logic              req1_ready;
  logic              otp_valid;
  logic [BITS/2-1:0] otp_data;
  logic              otp_ready;
  logic [BITS-1:0]   cip_message;
  logic [BITS/2-1:0] cip_otp;
  logic [BITS-1:0]   cip_result;
  logic [BITS-1:0]   cip_plain;
  logic              out_valid;
  logic [BITS-1:0]   out_data;
  logic              out_id;
  logic              out_err;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  msg_count;

  modport slave (
    input  req0_valid, req0_msg,
    input  req1_valid, req1_msg,
    input  otp_valid, otp_data,
    input  cip_result, cip_plain,
    input  out_ready,
    output req0_ready, req1_ready,
    output otp_ready,
    output cip_message, cip_otp,
    output out_valid, out_data,
    output out_id, out_err,
    output busy, msg_count
  );

  modport master (
    output req0_valid, req0_msg,
    output req1_valid, req1_msg,
    output otp_valid, otp_data,
    output cip_result, cip_plain,
    output out_ready,
    input  req0_ready, req1_ready,
    input  otp_ready,
    input  cip_message, cip_otp,
    input  out_valid, out_data,
    input  out_id, out_err,
    input  busy, msg_count
  );
endinterface

// File: rtl/otp_cipher_ctrl.sv
// Round-robin cipher sharing controller: binds each message to one pad
// word, waits the cipher latency, checks decipher, returns result.
// Ports: clk, rst_n (async low), bus (otp_cipher_ctrl_if.slave).
module otp_cipher_ctrl #(
  parameter int BITS       = 64,
  parameter int CIPHER_LAT = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  otp_cipher_ctrl_if.slave  bus
);
  localparam int PW = BITS / 2;
  localparam int LW = $clog2(CIPHER_LAT + 1);
  localparam logic [LW-1:0] LAT = LW'(CIPHER_LAT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [BITS-1:0]  cip_msg_q, cip_msg_d;
  logic [PW-1:0]    cip_otp_q, cip_otp_d;
  logic [BITS-1:0]  out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             last_id_q, last_id_d;
  logic [CNT_W-1:0] msg_count_q, msg_count_d;

  logic pick0, pick1;
  logic rdy0, rdy1, gnt;

  // On a tie the requester not served last wins.
  always_comb begin
    pick0 = bus.req0_valid
          & (~bus.req1_valid | last_id_q);
    pick1 = bus.req1_valid
          & (~bus.req0_valid | ~last_id_q);
    rdy0  = (state_q == IDLE)
          & bus.otp_valid & pick0;
    rdy1  = (state_q == IDLE)
          & bus.otp_valid & pick1;
    gnt   = rdy0 | rdy1;
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.otp_ready   = gnt;
  assign bus.cip_message = cip_msg_q;
  assign bus.cip_otp     = cip_otp_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_id      = out_id_q;
  assign bus.out_err     = out_err_q;
  assign bus.busy        = busy_q;
  assign bus.msg_count   = msg_count_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cip_msg_d   = cip_msg_q;
    cip_otp_d   = cip_otp_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;
    last_id_d   = last_id_q;
    msg_count_d = msg_count_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          cip_msg_d = rdy1 ? bus.req1_msg
                           : bus.req0_msg;
          cip_otp_d = bus.otp_data;
          out_id_d  = rdy1;
          last_id_d = rdy1;
          cnt_d     = '0;
          if (msg_count_q != '1)
            msg_count_d = msg_count_q + 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT) begin
          out_data_d = bus.cip_result;
          out_err_d  = bus.cip_plain != cip_msg_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = state_d != IDLE;
    out_valid_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cip_msg_q   <= '0;
      cip_otp_q   <= '0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      last_id_q   <= 1'b1;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cip_msg_q   <= cip_msg_d;
      cip_otp_q   <= cip_otp_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      last_id_q   <= last_id_d;
      msg_count_q <= msg_count_d;
    end
  end
endmodule

// File: tb/tb_otp_cipher_ctrl.sv
// Self-checking bench for otp_cipher_ctrl with an ideal
// two-stage cipher model and a 4-bit-counter saturation instance.
module tb_otp_cipher_ctrl;
  localparam int BITS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic corrupt = 1'b0;
  always #5 clk = ~clk;

  otp_cipher_ctrl_if #(.BITS(BITS), .CNT_W(16)) bus ();
  otp_cipher_ctrl_if #(.BITS(BITS), .CNT_W(4))  sbus ();

  otp_cipher_ctrl #(
    .BITS(BITS), .CIPHER_LAT(2), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  otp_cipher_ctrl #(
    .BITS(BITS), .CIPHER_LAT(2), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
  );

  // Ideal cipher: upper half XOR pad, two register stages.
  logic [BITS-1:0] res1, res2, pl1, pl2;
  always_ff @(posedge clk) begin
    res1 <= {bus.cip_message[63:32] ^ bus.cip_otp,
             bus.cip_message[31:0]};
    pl1  <= bus.cip_message;
    res2 <= res1;
    pl2  <= pl1;
  end
  assign bus.cip_result = res2;
  assign bus.cip_plain  = pl2 ^ {{(BITS-1){1'b0}}, corrupt};
  assign sbus.cip_result = sbus.cip_message;
  assign sbus.cip_plain  = sbus.cip_message;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for out_valid; lat counts edges after the grant edge.
  task automatic wait_valid(output int lat);
    bit got;
    got = 0;
    lat = 1;
    while (lat <= 12 && !got) begin
      @(posedge clk); #1;
      if (bus.out_valid) got = 1;
      else lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic        r0v;
    logic [63:0] r0m;
    logic        r1v;
    logic [63:0] r1m;
    logic [31:0] pad;
    logic        bad;
    logic        exp_id;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int i);
    vec_t v;
    int lat;
    v = vecs[i];
    bus.req0_valid = v.r0v;
    bus.req0_msg   = v.r0m;
    bus.req1_valid = v.r1v;
    bus.req1_msg   = v.r1m;
    bus.otp_data   = v.pad;
    bus.otp_valid  = 1'b1;
    corrupt        = v.bad;
    @(negedge clk);
    chk($sformatf("v%0d req0_ready", i),
        64'(bus.req0_ready), 64'(!v.exp_id));
    chk($sformatf("v%0d req1_ready", i),
        64'(bus.req1_ready), 64'(v.exp_id));
    chk($sformatf("v%0d otp_ready", i),
        64'(bus.otp_ready), 64'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.otp_valid  = 1'b0;
    chk($sformatf("v%0d msg_count", i),
        64'(bus.msg_count), 64'(i + 1));
    chk($sformatf("v%0d busy", i), 64'(bus.busy), 64'd1);
    wait_valid(lat);
    chk($sformatf("v%0d latency", i), 64'(lat), 64'd3);
    chk($sformatf("v%0d out_data", i), bus.out_data, v.exp_data);
    chk($sformatf("v%0d out_id", i),
        64'(bus.out_id), 64'(v.exp_id));
    chk($sformatf("v%0d out_err", i),
        64'(bus.out_err), 64'(v.exp_err));
    handshake();
    corrupt = 1'b0;
    chk($sformatf("v%0d valid drop", i), 64'(bus.out_valid), 64'd0);
    chk($sformatf("v%0d idle", i), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid[$];
    int gcyc[$];
    int pulses, both, stray, bad, lat, grants;

    vecs[0] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0,
                32'hDEAD_BEEF, 1'b0,
                1'b0, 64'hDF8E_FB88_89AB_CDEF, 1'b0};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 64'hFFFF_0000_1234_5678,
                32'h0F0F_0F0F, 1'b0,
                1'b1, 64'hF0F0_0F0F_1234_5678, 1'b0};
    vecs[2] = '{1'b1, 64'hA5A5_A5A5_0000_0001,
                1'b1, 64'h7777_7777_7777_7777,
                32'h5A5A_5A5A, 1'b0,
                1'b0, 64'hFFFF_FFFF_0000_0001, 1'b0};
    vecs[3] = '{1'b1, 64'h0000_0000_0000_0001,
                1'b1, 64'h0000_0000_FFFF_FFFF,
                32'h1234_5678, 1'b0,
                1'b1, 64'h1234_5678_FFFF_FFFF, 1'b0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 64'h8000_0000_0000_0000,
                32'h0000_0001, 1'b1,
                1'b1, 64'h8000_0001_0000_0000, 1'b1};

    bus.req0_valid = 0; bus.req0_msg = '0;
    bus.req1_valid = 0; bus.req1_msg = '0;
    bus.otp_valid  = 0; bus.otp_data = '0;
    bus.out_ready  = 0;
    sbus.req0_valid = 0; sbus.req0_msg = 64'h55;
    sbus.req1_valid = 0; sbus.req1_msg = '0;
    sbus.otp_valid  = 0; sbus.otp_data = 32'h1;
    sbus.out_ready  = 0;

    #12;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst msg_count", 64'(bus.msg_count), 64'd0);
    chk("rst cip_message", bus.cip_message, 64'd0);
    chk("rst out_data", bus.out_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Round robin with everything held ready.
    bus.req0_valid = 1; bus.req0_msg = 64'h1;
    bus.req1_valid = 1; bus.req1_msg = 64'h2;
    bus.otp_valid  = 1; bus.otp_data = 32'h3;
    bus.out_ready  = 1;
    pulses = 0; both = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.otp_ready) pulses++;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.otp_ready !== (bus.req0_ready | bus.req1_ready))
        both++;
      if (bus.req0_ready || bus.req1_ready) begin
        gid.push_back(int'(bus.req1_ready));
        gcyc.push_back(c);
      end
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.otp_valid = 0;
    chk("rr grants", 64'(gid.size()), 64'd4);
    chk("rr otp pulses", 64'(pulses), 64'd4);
    chk("rr ready excl", 64'(both), 64'd0);
    for (int k = 0; k < gid.size(); k++) begin
      chk($sformatf("rr id%0d", k), 64'(gid[k]), 64'(k % 2));
      chk($sformatf("rr cyc%0d", k), 64'(gcyc[k]), 64'(5 * k));
    end
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("rr msg_count", 64'(bus.msg_count), 64'd9);

    // Pad starvation.
    bus.req1_valid = 1; bus.req1_msg = 64'h1111_2222_3333_4444;
    bus.otp_data = 32'hFFFF_0000;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready || bus.otp_ready)
        stray++;
    end
    chk("starve no ready", 64'(stray), 64'd0);
    @(posedge clk); #1;
    bus.otp_valid = 1; #1;
    chk("starve req1_ready", 64'(bus.req1_ready), 64'd1);
    chk("starve otp_ready", 64'(bus.otp_ready), 64'd1);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_msg = 64'hCAFE_BABE_0000_0000;
    bus.otp_data = 32'h0F0F_0F0F;

    // Backpressure while req0 keeps asking.
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'd3);
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.out_data !== 64'hEEEE_2222_3333_4444) bad++;
      if (bus.out_id !== 1'b1 || bus.out_err !== 1'b0) bad++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) bad++;
      if (bus.req0_ready || bus.req1_ready || bus.otp_ready) bad++;
    end
    chk("bp stable", 64'(bad), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp no grant on hs", 64'(bus.req0_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("bp valid drop", 64'(bus.out_valid), 64'd0);
    chk("bp idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("bp resume grant", 64'(bus.req0_ready), 64'd1);
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.otp_valid = 0;
    wait_valid(lat);
    chk("bp2 data", bus.out_data, 64'hC5F1_B5B1_0000_0000);
    chk("bp2 id", 64'(bus.out_id), 64'd0);
    chk("bp2 msg_count", 64'(bus.msg_count), 64'd11);
    handshake();

    // Reset mid-WAIT.
    bus.req1_valid = 1; bus.req1_msg = 64'h9999_0000_0000_0000;
    bus.otp_valid = 1; bus.otp_data = 32'h1;
    @(posedge clk); #1;
    bus.req1_valid = 0; bus.otp_valid = 0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid rst busy", 64'(bus.busy), 64'd0);
    chk("mid rst msg_count", 64'(bus.msg_count), 64'd0);
    chk("mid rst cip_message", bus.cip_message, 64'd0);
    chk("mid rst cip_otp", 64'(bus.cip_otp), 64'd0);
    chk("mid rst out_data", bus.out_data, 64'd0);
    chk("mid rst out_id", 64'(bus.out_id), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) bad++;
    end
    chk("mid rst no result", 64'(bad), 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_msg = 64'h4;
    bus.req1_valid = 1; bus.req1_msg = 64'h5;
    bus.otp_valid = 1; #1;
    chk("post rst tie req0", 64'(bus.req0_ready), 64'd1);
    chk("post rst tie req1", 64'(bus.req1_ready), 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.otp_valid = 0;
    wait_valid(lat);
    chk("post rst id", 64'(bus.out_id), 64'd0);
    chk("post rst count", 64'(bus.msg_count), 64'd1);
    handshake();

    // Saturation of a 4-bit counter.
    sbus.req0_valid = 1; sbus.otp_valid = 1; sbus.out_ready = 1;
    grants = 0;
    for (int c = 0; c < 200 && grants < 17; c++) begin
      @(negedge clk);
      if (sbus.otp_ready) grants++;
    end
    @(posedge clk); #1;
    sbus.req0_valid = 0; sbus.otp_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("sat grants", 64'(grants), 64'd17);
    chk("sat msg_count", 64'(sbus.msg_count), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
